// File: rtl/fifo_stream_unpacker.sv
// Read-side FIFO consumer: pops DataWidth words and serialises each into
// Ratio OutWidth-wide beats on a valid/ready stream, prefetching on the last beat.
module fifo_stream_unpacker #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned OutWidth  = 8,
  parameter bit          LsbFirst  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 empty,
  input  logic [DataWidth-1:0] readData,
  output logic                 readEn,
  input  logic                 flush,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [OutWidth-1:0]  outData,
  output logic                 outLast,
  output logic                 busy
);

  localparam int unsigned Ratio = DataWidth / OutWidth;
  localparam int unsigned BeatW = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Ratio - 1);

  if ((DataWidth % OutWidth) != 0 || OutWidth == 0) begin : g_bad_ratio
    $error("fifo_stream_unpacker: DataWidth must be an integer multiple of OutWidth");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   initQ;
  logic [DataWidth-1:0]   wordQ, word_d;
  logic [BeatW-1:0]       beatQ, beat_d;
  logic                   holdV;
  logic                   lastBeat;
  logic                   xfer;
  logic                   lastXfer;

  assign holdV    = (state_q == SEND);
  assign lastBeat = (beatQ == LastBeat);
  assign xfer     = holdV & outReady;
  assign lastXfer = xfer & lastBeat;

  // Pop when idle, or on the final beat so the next word follows without a bubble.
  assign readEn   = initQ & ~rst & ~flush & ~empty & (~holdV | lastXfer);

  assign outValid = holdV;
  assign outLast  = holdV & lastBeat;
  assign busy     = holdV;

  always_comb begin
    outData = '0;
    for (int unsigned i = 0; i < Ratio; i++) begin
      if (beatQ == BeatW'(i)) begin
        if (LsbFirst) outData = wordQ[i*OutWidth +: OutWidth];
        else          outData = wordQ[(Ratio-1-i)*OutWidth +: OutWidth];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beatQ;
    word_d  = wordQ;
    case (state_q)
      IDLE: begin
        if (readEn) begin
          state_d = SEND;
          beat_d  = '0;
          word_d  = readData;
        end
      end
      SEND: begin
        if (flush) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (readEn) begin
          beat_d  = '0;
          word_d  = readData;
        end else if (lastXfer) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (xfer) begin
          beat_d  = beatQ + BeatW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      initQ   <= 1'b0;
      beatQ   <= '0;
      wordQ   <= '0;
    end else begin
      state_q <= state_d;
      initQ   <= 1'b1;
      beatQ   <= beat_d;
      wordQ   <= word_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_unpacker.sv
// Directed bench for fifo_stream_unpacker with a small behavioural FIFO on the read side.
module tb_fifo_stream_unpacker;

  logic        clk;
  logic        rst;
  logic        empty;
  logic [31:0] readData;
  logic        readEn;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [7:0]  outData;
  logic        outLast;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:15];
  int rdp = 0;
  int wrp = 0;

  fifo_stream_unpacker #(
    .DataWidth(32),
    .OutWidth (8),
    .LsbFirst (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .empty   (empty),
    .readData(readData),
    .readEn  (readEn),
    .flush   (flush),
    .outValid(outValid),
    .outReady(outReady),
    .outData (outData),
    .outLast (outLast),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign empty    = (rdp == wrp);
  assign readData = mem[rdp[3:0]];

  always @(posedge clk) begin
    if (readEn && !empty) rdp <= rdp + 1;
  end

  always @(negedge clk) begin
    tests++;
    assert (!(readEn && empty)) else begin
      fails++;
      $error("FAIL read_while_empty: observed readEn=%0b empty=%0b expected readEn=0", readEn, empty);
    end
  end

  task automatic push(input logic [31:0] w);
    mem[wrp[3:0]] = w;
    wrp = wrp + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [7:0] d, input logic last);
    chk({tag, "_valid"}, {31'd0, outValid}, 32'd1);
    chk({tag, "_data"},  {24'd0, outData},  {24'd0, d});
    chk({tag, "_last"},  {31'd0, outLast},  {31'd0, last});
  endtask

  task automatic idle(input string tag);
    chk({tag, "_valid"}, {31'd0, outValid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy},     32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    outReady = 1'b1;
    push(32'hA1B2C3D4);

    // Reset sequence
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_readEn", {31'd0, readEn}, 32'd0);
      idle("rst");
    end
    chk("rst_data", {24'd0, outData}, 32'd0);
    chk("rst_last", {31'd0, outLast}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst1_readEn", {31'd0, readEn}, 32'd0);
    tick();
    chk("post_rst2_readEn", {31'd0, readEn}, 32'd1);
    chk("post_rst2_valid", {31'd0, outValid}, 32'd0);

    // Single word, LSB first
    tick(); beat("w0b0", 8'hD4, 1'b0);
    chk("w0b0_readEn", {31'd0, readEn}, 32'd0);
    tick(); beat("w0b1", 8'hC3, 1'b0);
    tick(); beat("w0b2", 8'hB2, 1'b0);
    tick(); beat("w0b3", 8'hA1, 1'b1);
    chk("w0b3_readEn", {31'd0, readEn}, 32'd0);
    tick(); idle("w0_done");
    chk("w0_empty", {31'd0, empty}, 32'd1);

    // Back-to-back words, no bubble
    push(32'h00000001);
    push(32'h00000002);
    #1;
    chk("b2b_pop1", {31'd0, readEn}, 32'd1);
    tick(); beat("b2b_1b0", 8'h01, 1'b0);
    chk("b2b_1b0_readEn", {31'd0, readEn}, 32'd0);
    tick(); beat("b2b_1b1", 8'h00, 1'b0);
    tick(); beat("b2b_1b2", 8'h00, 1'b0);
    tick(); beat("b2b_1b3", 8'h00, 1'b1);
    chk("b2b_prefetch", {31'd0, readEn}, 32'd1);
    tick(); beat("b2b_2b0", 8'h02, 1'b0);
    chk("b2b_2b0_readEn", {31'd0, readEn}, 32'd0);
    tick(); beat("b2b_2b1", 8'h00, 1'b0);
    tick(); beat("b2b_2b2", 8'h00, 1'b0);
    tick(); beat("b2b_2b3", 8'h00, 1'b1);
    tick(); idle("b2b_done");

    // Backpressure on beat 1, with another word waiting
    push(32'h11223344);
    #1;
    chk("bp_pop", {31'd0, readEn}, 32'd1);
    tick(); beat("bp_b0", 8'h44, 1'b0);
    tick(); beat("bp_b1", 8'h33, 1'b0);
    outReady = 1'b0;
    push(32'hAABBCCDD);
    #1;
    for (int i = 0; i < 5; i++) begin
      beat("bp_stall", 8'h33, 1'b0);
      chk("bp_stall_readEn", {31'd0, readEn}, 32'd0);
      tick();
    end
    beat("bp_hold", 8'h33, 1'b0);
    outReady = 1'b1;
    #1;
    chk("bp_release_readEn", {31'd0, readEn}, 32'd0);
    tick(); beat("bp_b2", 8'h22, 1'b0);
    tick(); beat("bp_b3", 8'h11, 1'b1);
    chk("bp_prefetch", {31'd0, readEn}, 32'd1);
    tick(); beat("bp_nb0", 8'hDD, 1'b0);
    tick(); beat("bp_nb1", 8'hCC, 1'b0);
    tick(); beat("bp_nb2", 8'hBB, 1'b0);
    tick(); beat("bp_nb3", 8'hAA, 1'b1);
    tick(); idle("bp_done");

    // Flush at beat 2
    push(32'hDEADBEEF);
    push(32'h12345678);
    #1;
    tick(); beat("fl_b0", 8'hEF, 1'b0);
    tick(); beat("fl_b1", 8'hBE, 1'b0);
    tick(); beat("fl_b2", 8'hAD, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_readEn", {31'd0, readEn}, 32'd0);
    tick();
    idle("fl_after");
    chk("fl_after_readEn", {31'd0, readEn}, 32'd0);
    flush = 1'b0;
    #1;
    chk("fl_next_pop", {31'd0, readEn}, 32'd1);
    tick(); beat("fl_nb0", 8'h78, 1'b0);
    tick(); beat("fl_nb1", 8'h56, 1'b0);
    tick(); beat("fl_nb2", 8'h34, 1'b0);
    tick(); beat("fl_nb3", 8'h12, 1'b1);
    tick(); idle("fl_done");

    // Reset mid-word
    push(32'hDEADBEEF);
    push(32'h12345678);
    #1;
    tick(); beat("rs_b0", 8'hEF, 1'b0);
    tick(); beat("rs_b1", 8'hBE, 1'b0);
    rst = 1'b1;
    #1;
    chk("rs_readEn_in_rst", {31'd0, readEn}, 32'd0);
    tick();
    idle("rs_after");
    chk("rs_readEn_rst2", {31'd0, readEn}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rs_readEn_guard", {31'd0, readEn}, 32'd0);
    tick();
    chk("rs_readEn_resume", {31'd0, readEn}, 32'd1);
    tick(); beat("rs_nb0", 8'h78, 1'b0);
    tick(); beat("rs_nb1", 8'h56, 1'b0);
    tick(); beat("rs_nb2", 8'h34, 1'b0);
    tick(); beat("rs_nb3", 8'h12, 1'b1);
    tick(); idle("rs_done");

    // Empty boundary
    for (int i = 0; i < 6; i++) begin
      chk("em_readEn", {31'd0, readEn}, 32'd0);
      idle("em");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_stream_unpacker.md
Name: fifo_stream_unpacker

Overview:
- Read-side consumer of the synchronous FIFO; drains words through the FIFO's readEn/readData/empty interface.
- Serialises each DataWidth word into Ratio narrower beats on a valid/ready output stream.
- Prefetches the next word during the last beat, so output runs at one beat per cycle while the FIFO is non-empty.
- Never violates the FIFO's read-side contract: no read while empty, during reset, or in the first cycle after reset.

Parameters:
- DataWidth, 32, FIFO word width; must equal the FIFO's DataWidth.
- OutWidth, 8, output beat width; DataWidth must be an integer multiple of it (elaboration error otherwise).
- LsbFirst, 1, 1 = beat 0 is bits [OutWidth-1:0]; 0 = beat 0 is the most-significant slice.

Ports:
- clk  input  1  single clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- empty  input  1  FIFO empty flag.
- readData  input  DataWidth  FIFO head word; valid in the same cycle readEn is high.
- readEn  output  1  FIFO pop strobe.
- flush  input  1  synchronous discard of the held word.
- outValid  output  1  beat available.
- outReady  input  1  downstream accepts the beat.
- outData  output  OutWidth  current beat.
- outLast  output  1  high on the final beat of a word (beat index Ratio-1).
- busy  output  1  equals holdV (a word is held).

Behaviour:
- Ratio = DataWidth/OutWidth; beatQ is $clog2(Ratio) bits wide, minimum 1.
- State registers: initQ (post-reset guard), holdV, wordQ[DataWidth], beatQ.
- Reset (rst=1 at a clock edge): initQ=0, holdV=0, beatQ=0, wordQ=0.
- Reset outputs: readEn=0, outValid=0, outLast=0, outData=0, busy=0.
- initQ becomes 1 at the first edge with rst=0; readEn is forced 0 while initQ=0, i.e. during reset and the cycle after it.
- States: IDLE (holdV=0) and SEND (holdV=1).
- lastXfer = outValid & outReady & (beatQ==Ratio-1).
- readEn = initQ & !rst & !flush & !empty & (!holdV | lastXfer); combinational.
- Pop (readEn=1): at the next edge wordQ<=readData, holdV<=1, beatQ<=0 (state SEND).
- Beat transfer (outValid & outReady, not last beat): beatQ<=beatQ+1.
- lastXfer with no pop: holdV<=0, beatQ<=0 (state IDLE).
- lastXfer with pop in the same cycle: new word loaded; SEND continues with no bubble.
- outValid=holdV.
- outData = slice beatQ of wordQ: LsbFirst=1 gives wordQ[beatQ*OutWidth +: OutWidth]; LsbFirst=0 takes slices from the MSB end.
- outLast = holdV & (beatQ==Ratio-1).
- Latency: readEn high in cycle T gives first beat outValid in cycle T+1.
- Throughput: Ratio beats per word, zero idle cycles while empty=0 and outReady=1.
- Backpressure: while outValid & !outReady, outData, outLast and beatQ hold stable; no pop occurs.
- flush=1: holdV<=0, beatQ<=0, readEn=0 that cycle; a beat transfer in that cycle is discarded. Flush has priority over a pop.
- rst mid-word: the held word is lost, outValid drops at the next edge, and no pop occurs during rst or the following cycle.
- The empty flag is sampled combinationally; when empty=1, readEn=0 regardless of the other conditions.

Test Plan:
- Reset sequence: rst=1 for 3 cycles then 0, empty=0 -> readEn=0 during reset and the first cycle after, readEn=1 in the 2nd post-reset cycle; outValid=0 throughout reset.
- Single word, LsbFirst=1: readData=32'hA1B2C3D4, outReady=1 -> beats 8'hD4, C3, B2, A1 on consecutive cycles, outLast only on A1, then outValid=0 and FIFO empty.
- Back-to-back words: FIFO holds 32'h00000001 and 32'h00000002, outReady=1 -> 8 beats on 8 consecutive cycles; readEn pulses on the cycle of beat 3 of word 1; no bubble.
- Backpressure: outReady=0 for 5 cycles during beat 1 of 32'h11223344 -> outData holds 8'h33 stable, readEn=0 throughout, sequence resumes on release.
- Flush/reset mid-word: flush=1 at beat 2 of 32'hDEADBEEF -> outValid=0 next cycle, next FIFO word starts at beat 0; repeat with rst=1 -> readEn=0 for 2 cycles.
- Empty boundary: empty=1 with holdV=0 -> readEn=0 and outValid=0 indefinitely; readEn is never high while empty is high.
